apb_wdt: RTL and testbench

APB watchdog timer peripheral, downstream of the AHB-to-APB bridge on a free PSEL slot (PSEL[5]), with its read data returned through the APB response mux. It counts a loadable 32-bit value down from a prescaled PCLK. The first timeout raises an interrupt into INTISR. If the interrupt is not cleared before a second timeout, the block asserts a sticky system reset request.

---
 rtl/apb_wdt.sv | 156 +++++++++++++++
 tb/tb_apb_wdt.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/apb_wdt.sv
// APB watchdog: prescaled 32-bit down-counter, interrupt on first timeout, sticky reset request on second.
// Optional LOCK register at 0x18 is enabled by defining WDT_LOCK_EN.
module apb_wdt (
   input  logic        PCLK,
   input  logic        PRESET,
   input  logic        PSEL,
   input  logic        PENABLE,
   input  logic        PWRITE,
   input  logic [31:0] PADDR,
   input  logic [31:0] PWDATA,
   output logic [31:0] PRDATA,
   output logic        WDT_IRQ,
   output logic        WDT_RST
);
   localparam int unsigned DW = 32;
   localparam int unsigned PW = 8;
   localparam int unsigned AW = 3;

   localparam logic [AW-1:0] A_LOAD   = AW'(0);
   localparam logic [AW-1:0] A_VALUE  = AW'(1);
   localparam logic [AW-1:0] A_CTRL   = AW'(2);
   localparam logic [AW-1:0] A_INTCLR = AW'(3);
   localparam logic [AW-1:0] A_RIS    = AW'(4);
   localparam logic [AW-1:0] A_PRESC  = AW'(5);

   logic [DW-1:0] load_q, load_d;
   logic [DW-1:0] value_q, value_d;
   logic [PW-1:0] presc_q, presc_d;
   logic [PW-1:0] pcnt_q, pcnt_d;
   logic          en_q, en_d;
   logic          rsten_q, rsten_d;
   logic          ris_q, ris_d;
   logic          rst_req_q, rst_req_d;
   logic          irq_q;

   logic [AW-1:0] idx;
   logic          wr, cfg_ok, tick;
   logic          wr_load, wr_ctrl, wr_presc, wr_intclr, en_rise;
   logic          unused;

   assign unused = ^{PADDR[31:5], PADDR[1:0]};
   assign idx    = PADDR[4:2];
   assign wr     = PSEL & PENABLE & PWRITE;

`ifdef WDT_LOCK_EN
   localparam logic [AW-1:0] A_LOCK     = AW'(6);
   localparam logic [DW-1:0] UNLOCK_KEY = 32'h1ACC_E551;

   logic lock_q;

   // Any write to LOCK other than the key relocks the configuration registers.
   always_ff @(posedge PCLK or posedge PRESET) begin
      if (PRESET)
         lock_q <= 1'b1;
      else if (wr && idx == A_LOCK)
         lock_q <= (PWDATA != UNLOCK_KEY);
   end

   assign cfg_ok = ~lock_q;
`else
   assign cfg_ok = 1'b1;
`endif

   assign wr_load   = wr & cfg_ok & (idx == A_LOAD);
   assign wr_ctrl   = wr & cfg_ok & (idx == A_CTRL);
   assign wr_presc  = wr & cfg_ok & (idx == A_PRESC);
   assign wr_intclr = wr & (idx == A_INTCLR);
   assign en_rise   = wr_ctrl & PWDATA[0] & ~en_q;
   assign tick      = en_q & (pcnt_q == presc_q);

   // Next-state logic; register writes that reload the counter swallow a coincident tick.
   always_comb begin
      load_d    = load_q;
      value_d   = value_q;
      presc_d   = presc_q;
      pcnt_d    = pcnt_q;
      en_d      = en_q;
      rsten_d   = rsten_q;
      ris_d     = ris_q;
      rst_req_d = rst_req_q;

      if (wr_load)
         load_d = PWDATA;
      if (wr_ctrl) begin
         en_d    = PWDATA[0];
         rsten_d = PWDATA[1];
      end
      if (wr_presc)
         presc_d = PWDATA[PW-1:0];
      if (en_q)
         pcnt_d = tick ? '0 : PW'(pcnt_q + 1'b1);

      if (wr_load || wr_intclr || en_rise) begin
         value_d = load_d;
         pcnt_d  = '0;
         if (wr_intclr)
            ris_d = 1'b0;
      end else if (tick) begin
         if (value_q != '0) begin
            value_d = DW'(value_q - 1'b1);
         end else begin
            value_d = load_q;
            if (!ris_q)
               ris_d = 1'b1;
            else if (rsten_q)
               rst_req_d = 1'b1;
         end
      end
   end

   always_ff @(posedge PCLK or posedge PRESET) begin
      if (PRESET) begin
         load_q    <= '1;
         value_q   <= '1;
         presc_q   <= '0;
         pcnt_q    <= '0;
         en_q      <= 1'b0;
         rsten_q   <= 1'b0;
         ris_q     <= 1'b0;
         rst_req_q <= 1'b0;
         irq_q     <= 1'b0;
      end else begin
         load_q    <= load_d;
         value_q   <= value_d;
         presc_q   <= presc_d;
         pcnt_q    <= pcnt_d;
         en_q      <= en_d;
         rsten_q   <= rsten_d;
         ris_q     <= ris_d;
         rst_req_q <= rst_req_d;
         irq_q     <= ris_d & en_d;
      end
   end

   assign WDT_IRQ = irq_q;
   assign WDT_RST = rst_req_q;

   // Read mux is combinational: data is valid whenever the slave is selected for a read.
   always_comb begin
      PRDATA = '0;
      if (PSEL && !PWRITE) begin
         case (idx)
            A_LOAD:  PRDATA = load_q;
            A_VALUE: PRDATA = value_q;
            A_CTRL:  PRDATA = DW'({rsten_q, en_q});
            A_RIS:   PRDATA = DW'(ris_q);
            A_PRESC: PRDATA = DW'(presc_q);
`ifdef WDT_LOCK_EN
            A_LOCK:  PRDATA = DW'(lock_q);
`endif
            default: PRDATA = '0;
         endcase
      end
   end

endmodule

// File: tb/tb_apb_wdt.sv
// Directed bench for apb_wdt: expected values queued at stimulus time, popped when the DUT is sampled.
`timescale 1ns/1ps
module tb_apb_wdt;
   localparam logic [31:0] KEY     = 32'h1ACC_E551;
   localparam logic [31:0] R_LOAD  = 32'h00;
   localparam logic [31:0] R_VALUE = 32'h04;
   localparam logic [31:0] R_CTRL  = 32'h08;
   localparam logic [31:0] R_ICLR  = 32'h0C;
   localparam logic [31:0] R_RIS   = 32'h10;
   localparam logic [31:0] R_PRESC = 32'h14;
   localparam logic [31:0] R_LOCK  = 32'h18;

   logic        PCLK    = 1'b0;
   logic        PRESET  = 1'b1;
   logic        PSEL    = 1'b0;
   logic        PENABLE = 1'b0;
   logic        PWRITE  = 1'b0;
   logic [31:0] PADDR   = '0;
   logic [31:0] PWDATA  = '0;
   logic [31:0] PRDATA;
   logic        WDT_IRQ;
   logic        WDT_RST;

   int          checks = 0;
   int          errors = 0;
   logic [31:0] exp_q[$];

   always #5 PCLK = ~PCLK;

   apb_wdt dut (
      .PCLK(PCLK), .PRESET(PRESET), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
      .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .WDT_IRQ(WDT_IRQ), .WDT_RST(WDT_RST)
   );

   task automatic compare(input string tag, input logic [31:0] obs);
      logic [31:0] exp;
      checks++;
      if (exp_q.size() == 0) begin
         errors++;
         $display("FAIL %s scoreboard empty, observed=%h", tag, obs);
         return;
      end
      exp = exp_q.pop_front();
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      exp_q.push_back(exp);
      compare(tag, obs);
   endtask

   // Called #1 after an edge; returns #1 after the n-th following edge.
   task automatic step(input int n);
      repeat (n) @(posedge PCLK);
      #1;
   endtask

   // Write takes effect on the second edge after the call.
   task automatic apb_write(input logic [31:0] addr, input logic [31:0] data);
      PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = addr; PWDATA = data;
      step(1);
      PENABLE = 1'b1;
      step(1);
      PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
   endtask

   // PRDATA is combinational on PSEL & ~PWRITE, so it is sampled in the setup cycle.
   task automatic apb_read(input string tag, input logic [31:0] addr, input logic [31:0] exp);
      PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = addr;
      exp_q.push_back(exp);
      @(negedge PCLK);
      compare(tag, PRDATA);
      step(1);
      PENABLE = 1'b1;
      step(1);
      PSEL = 1'b0; PENABLE = 1'b0;
   endtask

   task automatic read_reset_values(input string pfx);
      apb_read({pfx, "_load"},  R_LOAD,  32'hFFFF_FFFF);
      apb_read({pfx, "_value"}, R_VALUE, 32'hFFFF_FFFF);
      apb_read({pfx, "_ctrl"},  R_CTRL,  32'h0);
      apb_read({pfx, "_ris"},   R_RIS,   32'h0);
      apb_read({pfx, "_presc"}, R_PRESC, 32'h0);
      check({pfx, "_irq"}, 32'(WDT_IRQ), 32'h0);
      check({pfx, "_rst"}, 32'(WDT_RST), 32'h0);
   endtask

   initial begin
      #50000;
      $display("FAIL watchdog sim time limit reached");
      $fatal(1);
   end

   initial begin
      // Power-up reset
      step(3);
      check("por_irq", 32'(WDT_IRQ), 32'h0);
      check("por_rst", 32'(WDT_RST), 32'h0);
      check("por_prdata", PRDATA, 32'h0);
      PRESET = 1'b0;
      step(1);
      read_reset_values("por");
      apb_read("por_intclr_rd", R_ICLR, 32'h0);
      apb_read("por_hole_rd", 32'h1C, 32'h0);
`ifdef WDT_LOCK_EN
      apb_read("por_lock", R_LOCK, 32'h1);
`else
      apb_read("por_lock", R_LOCK, 32'h0);
`endif
      apb_write(R_LOCK, KEY);

      // First timeout -> IRQ after 4 edges, second -> sticky reset 4 edges later
      apb_write(R_LOAD, 32'd3);
      apb_write(R_PRESC, 32'd0);
      apb_write(R_CTRL, 32'h3);
      for (int i = 1; i <= 3; i++) begin
         step(1);
         check("to_irq_early", 32'(WDT_IRQ), 32'h0);
      end
      step(1);
      check("to_irq_rise", 32'(WDT_IRQ), 32'h1);
      check("to_rst_low", 32'(WDT_RST), 32'h0);
      for (int i = 1; i <= 3; i++) begin
         step(1);
         check("to_rst_early", 32'(WDT_RST), 32'h0);
      end
      step(1);
      check("to_rst_rise", 32'(WDT_RST), 32'h1);
      step(10);
      check("to_rst_hold", 32'(WDT_RST), 32'h1);
      apb_read("to_ris", R_RIS, 32'h1);
      apb_write(R_ICLR, 32'h0);
      check("to_rst_sticky", 32'(WDT_RST), 32'h1);
      check("to_irq_cleared", 32'(WDT_IRQ), 32'h0);

      // Reset in the middle of counting clears everything, including the reset request
      #3 PRESET = 1'b1;
      #1;
      check("mid_rst_async", 32'(WDT_RST), 32'h0);
      check("mid_irq_async", 32'(WDT_IRQ), 32'h0);
      step(2);
      PRESET = 1'b0;
      step(1);
      read_reset_values("mid");
      apb_write(R_LOCK, KEY);

      // Servicing the interrupt keeps the reset request away
      apb_write(R_LOAD, 32'd3);
      apb_write(R_PRESC, 32'd0);
      apb_write(R_CTRL, 32'h3);
      step(4);
      check("svc_irq_rise", 32'(WDT_IRQ), 32'h1);
      apb_write(R_ICLR, 32'h0);
      check("svc_irq_clr", 32'(WDT_IRQ), 32'h0);
      apb_read("svc_value", R_VALUE, 32'd3);
      for (int i = 0; i < 8; i++) begin
         apb_write(R_ICLR, 32'h0);
         step(1);
         check("svc_rst_loop", 32'(WDT_RST), 32'h0);
         check("svc_irq_loop", 32'(WDT_IRQ), 32'h0);
      end
      apb_read("svc_ris", R_RIS, 32'h0);
      check("svc_rst_end", 32'(WDT_RST), 32'h0);

      // Prescaler: LOAD=2, PRESC=1, RSTEN=0
      apb_write(R_CTRL, 32'h0);
      apb_write(R_ICLR, 32'h0);
      apb_write(R_LOAD, 32'd2);
      apb_write(R_PRESC, 32'd1);
      apb_write(R_CTRL, 32'h1);
      step(5);
      check("psc_irq_early", 32'(WDT_IRQ), 32'h0);
      step(1);
      check("psc_irq_rise", 32'(WDT_IRQ), 32'h1);
      apb_read("psc_value2", R_VALUE, 32'd2);
      apb_read("psc_value1", R_VALUE, 32'd1);
      apb_read("psc_value0", R_VALUE, 32'd0);
      check("psc_rst_2nd", 32'(WDT_RST), 32'h0);
      check("psc_irq_hold", 32'(WDT_IRQ), 32'h1);
      step(6);
      check("psc_rst_3rd", 32'(WDT_RST), 32'h0);
      step(1);
      apb_write(R_CTRL, 32'h0);
      check("dis_irq_low", 32'(WDT_IRQ), 32'h0);
      apb_read("dis_ris_held", R_RIS, 32'h1);
      apb_read("dis_value", R_VALUE, 32'd1);
      step(5);
      apb_read("dis_value_frozen", R_VALUE, 32'd1);
      apb_read("dis_ctrl", R_CTRL, 32'h0);

      // INTCLR lands on the tick that would raise the reset request
      apb_write(R_ICLR, 32'h0);
      apb_write(R_LOAD, 32'd3);
      apb_write(R_PRESC, 32'd0);
      apb_write(R_CTRL, 32'h3);
      step(4);
      check("cf_irq_rise", 32'(WDT_IRQ), 32'h1);
      step(2);
      apb_write(R_ICLR, 32'h0);
      check("cf_rst", 32'(WDT_RST), 32'h0);
      check("cf_irq", 32'(WDT_IRQ), 32'h0);
      apb_read("cf_value", R_VALUE, 32'd3);
      apb_read("cf_ris", R_RIS, 32'h0);
      check("cf_rst_after", 32'(WDT_RST), 32'h0);
      apb_read("cf_ctrl", R_CTRL, 32'h3);

      // LOCK register
      PRESET = 1'b1;
      step(2);
      PRESET = 1'b0;
      step(1);
`ifdef WDT_LOCK_EN
      apb_write(R_LOAD, 32'd5);
      apb_read("lk_load_locked", R_LOAD, 32'hFFFF_FFFF);
      apb_read("lk_lock_1", R_LOCK, 32'h1);
      apb_write(R_LOCK, KEY);
      apb_write(R_LOAD, 32'd5);
      apb_read("lk_load_open", R_LOAD, 32'd5);
      apb_read("lk_lock_0", R_LOCK, 32'h0);
      apb_write(R_LOCK, 32'h0);
      apb_read("lk_relock", R_LOCK, 32'h1);
      apb_write(R_PRESC, 32'd7);
      apb_read("lk_presc_locked", R_PRESC, 32'h0);
`else
      apb_write(R_LOCK, 32'h0);
      apb_read("nolk_lock_rd", R_LOCK, 32'h0);
      apb_write(R_LOAD, 32'd5);
      apb_read("nolk_load", R_LOAD, 32'd5);
      apb_read("nolk_value", R_VALUE, 32'd5);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
